// File: rtl/cs_registers_mtrap.sv
// rtl/cs_registers_mtrap.sv - machine-mode CSR file with interrupts, vectored traps, mret and 64-bit counters
//
// Purpose: serves CSR read/write/set/clear from the execute stage, steers trap
// entry (exceptions and interrupts) and mret, tracks M/U privilege and keeps
// mcycle/minstret.
// Ports:
//   clk_i, resetb_i, clk_en_i, exs_en_i          clock, async active-low reset, enables
//   rd_i, rd_addr_i, rd_data_o                    CSR read strobe/address, registered data
//   rd_illegal_rd_o, rd_illegal_wr_o              combinational access-fault flags
//   wr_i, wr_mode_i, wr_addr_i, wr_data_i         write-back (01 write, 10 set, 11 clear)
//   excp_*_i, excp_pc_i, excp_tval_i              exception sources, faulting pc, bad value
//   irq_ext_i, irq_tmr_i, irq_sw_i, irq_o         interrupt lines, pending-and-enabled
//   irq_take_i, retire_i, trap_rtn_i              interrupt accepted, retire, mret
//   trap_entry_addr_o, trap_rtn_addr_o, hpl_o     trap vector, mepc, current privilege
module cs_registers_mtrap #(
    parameter int unsigned C_XLEN         = 32,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] C_HART_ID      = 32'h0000_0000,
    parameter bit          C_COUNTERS     = 1'b1
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              exs_en_i,
    input  logic              rd_i,
    input  logic [11:0]       rd_addr_i,
    output logic [C_XLEN-1:0] rd_data_o,
    output logic              rd_illegal_rd_o,
    output logic              rd_illegal_wr_o,
    input  logic              wr_i,
    input  logic [1:0]        wr_mode_i,
    input  logic [11:0]       wr_addr_i,
    input  logic [C_XLEN-1:0] wr_data_i,
    input  logic              excp_ferr_i,
    input  logic              excp_uerr_i,
    input  logic              excp_maif_i,
    input  logic              excp_mala_i,
    input  logic              excp_masa_i,
    input  logic              excp_ilgl_i,
    input  logic [C_XLEN-1:0] excp_pc_i,
    input  logic [C_XLEN-1:0] excp_tval_i,
    input  logic              irq_ext_i,
    input  logic              irq_tmr_i,
    input  logic              irq_sw_i,
    output logic              irq_o,
    input  logic              irq_take_i,
    input  logic              retire_i,
    input  logic              trap_rtn_i,
    output logic [C_XLEN-1:0] trap_entry_addr_o,
    output logic [C_XLEN-1:0] trap_rtn_addr_o,
    output logic [1:0]        hpl_o
);

    // mode_q: 1 = machine, 0 = user
    logic        mode_q, mode_d;
    logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [1:0]  st_mpp_q, st_mpp_d;
    logic [2:0]  mie_q, mie_d;          // {MEIE, MTIE, MSIE}
    logic [1:0]  inhibit_q, inhibit_d;  // {IR, CY}
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, rd_data_q, rd_data_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [31:0] mip_w, mie_w, mstatus_w, wr_old, wr_val, excp_cause, excp_tval_w;
    logic [2:0]  irq_pend;
    logic [3:0]  irq_code;
    logic        qual, excp_any;

    assign hpl_o     = mode_q ? 2'b11 : 2'b00;
    assign mip_w     = {20'b0, irq_ext_i, 3'b0, irq_tmr_i, 3'b0, irq_sw_i, 3'b0};
    assign mie_w     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
    assign mstatus_w = {19'b0, st_mpp_q, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};

    function automatic logic csr_exists(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_exists = 1'b1;
            12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82:                    csr_exists = C_COUNTERS;
            default:                                               csr_exists = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_read(input logic [11:0] a);
        csr_read = 32'h0;
        case (a)
            12'h300: csr_read = mstatus_w;
            12'h301: csr_read = 32'h4010_0100;
            12'h304: csr_read = mie_w;
            12'h305: csr_read = mtvec_q;
            12'h340: csr_read = mscratch_q;
            12'h341: csr_read = {mepc_q[31:2], 2'b00};
            12'h342: csr_read = mcause_q;
            12'h343: csr_read = mtval_q;
            12'h344: csr_read = mip_w;
            12'hF14: csr_read = C_HART_ID;
            default: csr_read = 32'h0;
        endcase
        if (C_COUNTERS) begin
            case (a)
                12'h320:          csr_read = {29'b0, inhibit_q[1], 1'b0, inhibit_q[0]};
                12'hB00, 12'hC00: csr_read = mcycle_q[31:0];
                12'hB80, 12'hC80: csr_read = mcycle_q[63:32];
                12'hB02, 12'hC02: csr_read = minstret_q[31:0];
                12'hB82, 12'hC82: csr_read = minstret_q[63:32];
                default:          ;
            endcase
        end
    endfunction

    assign rd_illegal_rd_o = !csr_exists(rd_addr_i) || (rd_addr_i[9:8] > hpl_o);
    assign rd_illegal_wr_o = rd_illegal_rd_o || (rd_addr_i[11:10] == 2'b11);

    // U mode always accepts M-level interrupts regardless of mstatus.MIE
    assign irq_pend = mie_q & {irq_ext_i, irq_tmr_i, irq_sw_i};
    assign irq_o    = (st_mie_q || !mode_q) && (|irq_pend);
    assign irq_code = irq_pend[2] ? 4'd11 : (irq_pend[0] ? 4'd3 : 4'd7);

    assign excp_any = excp_ferr_i | excp_uerr_i | excp_maif_i | excp_mala_i | excp_masa_i | excp_ilgl_i;

    always_comb begin
        excp_cause  = 32'd2;
        excp_tval_w = excp_tval_i;
        if (excp_ferr_i)      excp_cause = 32'd1;
        else if (excp_uerr_i) begin excp_cause = 32'd2; excp_tval_w = 32'h0; end
        else if (excp_maif_i) excp_cause = 32'd0;
        else if (excp_mala_i) excp_cause = 32'd4;
        else if (excp_masa_i) excp_cause = 32'd6;
        else                  begin excp_cause = 32'd2; excp_tval_w = 32'h0; end
    end

    // Vector offset applies only when an interrupt, not an exception, is being steered
    always_comb begin
        trap_entry_addr_o = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && (|irq_pend) && !excp_any)
            trap_entry_addr_o = {mtvec_q[31:2], 2'b00} + {26'b0, irq_code, 2'b00};
    end

    assign trap_rtn_addr_o = {mepc_q[31:2], 2'b00};
    assign rd_data_o       = rd_data_q;

    assign qual   = clk_en_i & exs_en_i;
    assign wr_old = csr_read(wr_addr_i);

    always_comb begin
        case (wr_mode_i)
            2'b10:   wr_val = wr_old | wr_data_i;
            2'b11:   wr_val = wr_old & ~wr_data_i;
            default: wr_val = wr_data_i;
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        st_mpp_d   = st_mpp_q;
        mie_d      = mie_q;
        inhibit_d  = inhibit_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        rd_data_d  = rd_data_q;
        mcycle_d   = mcycle_q;
        minstret_d = minstret_q;

        if (!inhibit_q[0])
            mcycle_d = mcycle_q + 64'd1;
        if (exs_en_i && retire_i && !inhibit_q[1])
            minstret_d = minstret_q + 64'd1;

        if (qual && rd_i)
            rd_data_d = rd_illegal_rd_o ? 32'h0 : csr_read(rd_addr_i);

        if (qual && (excp_any || irq_take_i)) begin
            mepc_d    = {excp_pc_i[31:2], 2'b00};
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            st_mpp_d  = hpl_o;
            mode_d    = 1'b1;
            if (excp_any) begin
                mcause_d = excp_cause;
                mtval_d  = excp_tval_w;
            end else begin
                mcause_d = {1'b1, 27'b0, irq_code};
                mtval_d  = 32'h0;
            end
        end else if (qual && trap_rtn_i) begin
            mode_d    = (st_mpp_q == 2'b11);
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            st_mpp_d  = 2'b00;
        end else if (qual && wr_i && wr_mode_i != 2'b00) begin
            case (wr_addr_i)
                12'h300: begin
                    st_mie_d  = wr_val[3];
                    st_mpie_d = wr_val[7];
                    st_mpp_d  = (wr_val[12:11] == 2'b11) ? 2'b11 : 2'b00;
                end
                12'h304: mie_d      = {wr_val[11], wr_val[7], wr_val[3]};
                12'h305: mtvec_d    = {wr_val[31:2], (wr_val[1] ? 2'b00 : wr_val[1:0])};
                12'h340: mscratch_d = wr_val;
                12'h341: mepc_d     = {wr_val[31:2], 2'b00};
                12'h342: mcause_d   = wr_val;
                12'h343: mtval_d    = wr_val;
                default: ;
            endcase
            // A write to either half replaces the incremented value for the whole counter
            if (C_COUNTERS) begin
                case (wr_addr_i)
                    12'h320: inhibit_d  = {wr_val[2], wr_val[0]};
                    12'hB00: mcycle_d   = {mcycle_q[63:32], wr_val};
                    12'hB80: mcycle_d   = {wr_val, mcycle_q[31:0]};
                    12'hB02: minstret_d = {minstret_q[63:32], wr_val};
                    12'hB82: minstret_d = {wr_val, minstret_q[31:0]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            mode_q     <= 1'b1;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            st_mpp_q   <= 2'b00;
            mie_q      <= 3'b000;
            inhibit_q  <= 2'b00;
            mtvec_q    <= {C_RESET_VECTOR[31:2], 2'b00};
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            rd_data_q  <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else if (clk_en_i) begin
            mode_q     <= mode_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            st_mpp_q   <= st_mpp_d;
            mie_q      <= mie_d;
            inhibit_q  <= inhibit_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            rd_data_q  <= rd_data_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule
